// File: rtl/button_debouncer.sv
// button_debouncer: synchronise, debounce and edge-detect board push-buttons with sticky press flags
module button_debouncer #(
    parameter int NUM_BUTTONS       = 5,
    parameter int ACTIVE_LOW        = 1,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    input  logic [NUM_BUTTONS-1:0] clear_mask,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_press_pulse,
    output logic [NUM_BUTTONS-1:0] press_latched,
    output logic                   event_any
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [NUM_BUTTONS-1:0] INV = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_BUTTONS-1:0] state_q, state_d, press_q, press_d, release_q, release_d;
    logic [NUM_BUTTONS-1:0] long_q, long_d, latched_q, latched_d, accept;
    logic [NUM_BUTTONS-1:0][DW-1:0] deb_q, deb_d;
    logic [NUM_BUTTONS-1:0][HW-1:0] hold_q, hold_d;

    // next state: normalise pads, count stable mismatches, derive pulses and sticky flags
    always_comb begin
        sync1_d = btn_in ^ INV;
        sync2_d = sync1_q;
        accept  = '0;
        deb_d   = '0;
        hold_d  = '0;
        long_d  = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            accept[i] = (sync2_q[i] != state_q[i]) && (deb_q[i] == DEB_LAST);
            deb_d[i]  = (sync2_q[i] == state_q[i] || accept[i]) ? '0 : deb_q[i] + 1'b1;
            hold_d[i] = !state_q[i] ? '0 : (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + 1'b1;
            long_d[i] = state_q[i] && (hold_q[i] == HOLD_LAST);
        end
        state_d   = state_q ^ accept;
        press_d   = accept & ~state_q;
        release_d = accept & state_q;
        latched_d = (latched_q & ~clear_mask) | press_q;
    end

    // state registers; reset discards every partial count and returns pads to "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            latched_q <= '0;
            deb_q     <= '0;
            hold_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            latched_q <= latched_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
        end
    end

    assign btn_state        = state_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;
    assign press_latched    = latched_q;
    assign event_any        = |latched_q;
endmodule
